// File: rtl/fp_serializer_pkg.sv
// Shared definitions for the 8-bit float stream and its serial framing.
// Reused by the converter and the serial back end.
package fp_serializer_pkg;

   localparam int FP_W       = 8;
   localparam int FRAME_BITS = 11;

   localparam int S_POS = 7;
   localparam int E_MSB = 6;
   localparam int E_LSB = 4;
   localparam int F_MSB = 3;
   localparam int F_LSB = 0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_t;

   function automatic logic [FP_W-1:0] fp_pack(
      input logic       s,
      input logic [2:0] e,
      input logic [3:0] f
   );
      logic [FP_W-1:0] b;
      b              = '0;
      b[S_POS]       = s;
      b[E_MSB:E_LSB] = e;
      b[F_MSB:F_LSB] = f;
      return b;
   endfunction

endpackage

// File: rtl/fp_fifo.sv
// Small word FIFO between the converter and the serial line.
// Storage is register based; the head word is read from the register array.
module fp_fifo
   import fp_serializer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic [FP_W-1:0]              i_data,
   output logic [FP_W-1:0]              o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [FP_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]   r_wr;
   logic [AW-1:0]   r_rd;
   logic [CW-1:0]   r_count;

   logic            w_full;
   logic            w_empty;
   logic            w_do_push;
   logic            w_do_pop;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_do_push = i_push & ~w_full;
   assign w_do_pop  = i_pop & ~w_empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop)  r_rd <= r_rd + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Data storage needs no reset; only occupied slots are ever read.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr] <= i_data;
   end

   assign o_head  = r_mem[r_rd];
   assign o_count = r_count;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/fp_serializer.sv
// Buffers 8-bit float words and sends each as an 11-bit async frame:
// start(0), data MSB first, even parity, stop(1).
module fp_serializer
   import fp_serializer_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int BIT_DIV = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_s,
   input  logic [2:0]                   in_e,
   input  logic [3:0]                   in_f,
   output logic                         tx_out,
   output logic                         tx_busy,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int DW        = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
   localparam int DATA_BITS = FRAME_BITS - 3;
   localparam int BW        = $clog2(DATA_BITS);

   localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   tx_state_t       r_state;
   tx_state_t       w_state_nxt;
   logic            r_tx;
   logic            w_tx_nxt;
   logic            r_busy;
   logic [DW-1:0]   r_div;
   logic [DW-1:0]   w_div_nxt;
   logic [BW-1:0]   r_bit;
   logic [BW-1:0]   w_bit_nxt;
   logic [FP_W-1:0] r_sh;
   logic [FP_W-1:0] w_sh_nxt;
   logic            r_par;
   logic            w_par_nxt;

   logic [FP_W-1:0] w_byte;
   logic [FP_W-1:0] w_head;
   logic            w_push;
   logic            w_pop;
   logic            w_full;
   logic            w_empty;
   logic            w_div_end;

   assign w_byte    = fp_pack(in_s, in_e, in_f);
   assign w_push    = in_valid & ~w_full;
   assign w_div_end = (r_div == DIV_LAST);

   fp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_byte),
      .o_head  (w_head),
      .o_count (fifo_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-state, next line level and datapath updates for the frame FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = r_tx;
      w_div_nxt   = r_div + 1'b1;
      w_bit_nxt   = r_bit;
      w_sh_nxt    = r_sh;
      w_par_nxt   = r_par;
      w_pop       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_div_nxt = '0;
            w_bit_nxt = '0;
            w_tx_nxt  = 1'b1;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_sh_nxt    = w_head;
               w_par_nxt   = ^w_head;
               w_tx_nxt    = 1'b0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_div_end) begin
               w_div_nxt   = '0;
               w_tx_nxt    = r_sh[FP_W-1];
               w_state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (w_div_end) begin
               w_div_nxt = '0;
               if (r_bit == BIT_LAST) begin
                  w_bit_nxt   = '0;
                  w_tx_nxt    = r_par;
                  w_state_nxt = S_PARITY;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
                  w_sh_nxt  = {r_sh[FP_W-2:0], 1'b0};
                  w_tx_nxt  = r_sh[FP_W-2];
               end
            end
         end
         S_PARITY: begin
            if (w_div_end) begin
               w_div_nxt   = '0;
               w_tx_nxt    = 1'b1;
               w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (w_div_end) begin
               w_div_nxt   = '0;
               w_tx_nxt    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_div_nxt   = '0;
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and line registers; reset forces the line idle at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_div   <= '0;
         r_bit   <= '0;
         r_sh    <= '0;
         r_par   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_sh    <= w_sh_nxt;
         r_par   <= w_par_nxt;
      end
   end

   assign tx_out   = r_tx;
   assign tx_busy  = r_busy;
   assign in_ready = ~w_full;

endmodule
